// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op encodings, bus widths and FSM states for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MULDIV_OP_W = 3;

    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULT  = 3'd0;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MULTU = 3'd1;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_DIV   = 3'd2;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_DIVU  = 3'd3;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MADD  = 3'd4;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MADDU = 3'd5;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MSUB  = 3'd6;
    localparam logic [MULDIV_OP_W-1:0] MULDIV_OP_MSUBU = 3'd7;

    localparam logic [1:0] MULDIV_ST_IDLE = 2'd0;
    localparam logic [1:0] MULDIV_ST_MUL  = 2'd1;
    localparam logic [1:0] MULDIV_ST_DIV  = 2'd2;
    localparam logic [1:0] MULDIV_ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = MULDIV_ST_IDLE,
        ST_MUL  = MULDIV_ST_MUL,
        ST_DIV  = MULDIV_ST_DIV,
        ST_DONE = MULDIV_ST_DONE
    } muldiv_state_t;

    // Even op codes are the signed variants
    function automatic logic op_is_signed(input logic [MULDIV_OP_W-1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Request/response bundle between EX stage and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
) ();

    logic                               start_i;
    logic [muldiv_pkg::MULDIV_OP_W-1:0] op_i;
    logic [WIDTH-1:0]                   opdata1_i;
    logic [WIDTH-1:0]                   opdata2_i;
    logic [2*WIDTH-1:0]                 hilo_i;
    logic                               annul_i;
    logic                               busy_o;
    logic                               ready_o;
    logic [2*WIDTH-1:0]                 result_o;
    logic                               div_zero_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        input  busy_o, ready_o, result_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        output busy_o, ready_o, result_o, div_zero_o
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_restoring_step
// Brief    : One combinational iteration of restoring division.
// Revision : 1.0 - initial release
// ============================================================================
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_rem_msb;

    // Remainder stays below the divisor, so its MSB is always clear on entry
    assign w_shift          = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};
    assign w_diff           = {1'b0, w_shift} - {2'b00, i_div};
    assign o_rem            = w_diff[WIDTH+1] ? w_shift : w_diff[WIDTH:0];
    assign o_quo            = {i_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};
    assign w_unused_rem_msb = i_rem[WIDTH];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative radix-2 MULT/DIV unit producing {HI,LO}.
//            Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int C_W2 = 2 * WIDTH;

    muldiv_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic             r_rsign;
    logic             r_busy;
    logic             r_ready;
    logic             r_div_zero;
    logic [C_W2-1:0]  r_result;
    logic [C_W2-1:0]  r_acc;
    logic [C_W2-1:0]  r_mcand;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;

    logic             w_op1_neg;
    logic             w_op2_neg;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_is_div;
    logic             w_last;
    logic [C_W2-1:0]  w_acc_next;
    logic [C_W2-1:0]  w_prod;
    logic [C_W2-1:0]  w_mul_res;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_fin;
    logic [WIDTH-1:0] w_rem_fin;

    assign w_op1_neg = op_is_signed(bus.op_i) & bus.opdata1_i[WIDTH-1];
    assign w_op2_neg = op_is_signed(bus.op_i) & bus.opdata2_i[WIDTH-1];
    assign w_mag1    = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign w_mag2    = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    assign w_is_div  = (bus.op_i == MULDIV_OP_DIV) || (bus.op_i == MULDIV_OP_DIVU);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply: r_op2 shifts right, multiplicand shifts left into the 2W accumulator
    assign w_acc_next = r_op2[0] ? (r_acc + r_mcand) : r_acc;
    assign w_prod     = r_sign ? -w_acc_next : w_acc_next;

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_op2),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    assign w_quo_fin = r_sign  ? -w_quo_next : w_quo_next;
    assign w_rem_fin = r_rsign ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];

`ifdef MULDIV_MADD_EN
    logic [C_W2-1:0] r_hilo;
    logic            r_accum;
    logic            r_sub;

    assign w_mul_res = !r_accum ? w_prod :
                       r_sub    ? (r_hilo - w_prod) : (r_hilo + w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hilo  <= '0;
            r_accum <= 1'b0;
            r_sub   <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start_i && !bus.annul_i) begin
            r_hilo  <= bus.hilo_i;
            r_accum <= bus.op_i[2];
            r_sub   <= bus.op_i[1];
        end
    end
`else
    logic w_unused_hilo;

    assign w_mul_res     = w_prod;
    assign w_unused_hilo = ^bus.hilo_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_rsign    <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_op2      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        r_cnt   <= '0;
                        r_sign  <= w_op1_neg ^ w_op2_neg;
                        r_rsign <= w_op1_neg;
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_mag1};
                        r_op2   <= w_mag2;
                        r_rem   <= '0;
                        r_quo   <= w_mag1;
                        r_busy  <= 1'b1;
                        if (w_is_div && bus.opdata2_i == '0) begin
                            r_state    <= ST_DONE;
                            r_ready    <= 1'b1;
                            r_div_zero <= 1'b1;
                            r_result   <= {bus.opdata1_i, {WIDTH{1'b1}}};
                        end else if (w_is_div) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (bus.annul_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_mcand <= r_mcand << 1;
                        r_op2   <= r_op2 >> 1;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_ready    <= 1'b1;
                            r_div_zero <= 1'b0;
                            r_result   <= w_mul_res;
                        end
                    end
                end
                ST_DIV: begin
                    if (bus.annul_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_ready    <= 1'b1;
                            r_div_zero <= 1'b0;
                            r_result   <= {w_rem_fin, w_quo_fin};
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.ready_o    = r_ready;
    assign bus.result_o   = r_result;
    assign bus.div_zero_o = r_div_zero;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the EX stage. It computes MIPS MULT/MULTU/DIV/DIVU, and optionally MADD/MADDU/MSUB/MSUBU, into a {HI,LO} result. It replaces the single-cycle combinational multiplier with an iterative radix-2 engine. EX holds the pipeline while `busy_o` is high, and writes HI/LO when `ready_o` pulses.

## Interface
Parameters:
- `WIDTH`, 32: operand width; result is 2*WIDTH.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; synchronous, active-high.
- `start_i`  in  1  request; sampled in IDLE only.
- `op_i`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `opdata1_i`  in  WIDTH  multiplicand / dividend.
- `opdata2_i`  in  WIDTH  multiplier / divisor.
- `hilo_i`  in  2*WIDTH  forwarded current {HI,LO}, used by accumulate ops.
- `annul_i`  in  1  flush; cancels any in-flight operation.
- `busy_o`  out  1  high in every state except IDLE.
- `ready_o`  out  1  one-cycle pulse; `result_o` is valid in that cycle.
- `result_o`  out  2*WIDTH  {HI,LO}; holds its value until the next `ready_o`.
- `div_zero_o`  out  1  divisor was zero; valid with `ready_o`, held with `result_o`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Transitions:
  - IDLE→MUL/DIV on `start_i` with `!annul_i`.
  - MUL/DIV→DONE after WIDTH iterations.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `annul_i`.
- Capture at start:
  - Signed ops take magnitudes of both operands and latch `sign_q = op1[W-1]^op2[W-1]` and `rsign_q = op1[W-1]`.
  - Unsigned ops latch the operands unchanged, with signs 0.
  - `hilo_i` is latched at start.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
- DIV: restoring division, one quotient bit per cycle.
  - Remainder register is WIDTH+1 bits.
  - Subtract the divisor; restore if the result is negative.
- DONE:
  - Product is negated if `sign_q`.
  - Quotient is negated if `sign_q`; remainder is negated if `rsign_q`.
  - Result is {HI=remainder, LO=quotient}.
  - Accumulate ops add (MADD/MADDU) or subtract (MSUB/MSUBU) the final product to/from the latched hilo, modulo 2^(2*WIDTH).
- Divide by zero, detected at start:
  - Skip iteration and go straight to DONE.
  - `result_o` = {opdata1_i, all ones}; `div_zero_o`=1.
- Signed most-negative / -1 gives quotient = most-negative (wrap) and remainder 0. No trap.
- `start_i` while busy is ignored.
- `start_i` and `annul_i` in the same cycle: start is ignored.

## Timing
- Reset values: state IDLE; `busy_o`=0; `ready_o`=0; `result_o`=0; `div_zero_o`=0; counter 0.
- Normal latency:
  - Start sampled at edge N.
  - `busy_o` is high from cycle N+1 through N+WIDTH+1.
  - `ready_o` is high only in cycle N+WIDTH+1 (DONE).
  - IDLE at N+WIDTH+2.
- Divide by zero: `ready_o` is high at N+1.
- Throughput: the next start can be accepted in the IDLE cycle after DONE. There is no start in DONE.
- `result_o` and `div_zero_o` are registered on entry to DONE.
- `annul_i` in MUL/DIV:
  - IDLE next cycle; no `ready_o`.
  - `result_o` keeps its previous value.
- `annul_i` during DONE does not suppress that cycle's `ready_o`; it only forces IDLE next.
- `rst` mid-operation returns to reset values on the next edge.

## Configuration
- `MULDIV_MADD_EN` defined: ops 4–7 accumulate as described.
- Undefined:
  - Ops 4/6 behave as MULT and 5/7 as MULTU.
  - `hilo_i` is ignored and the accumulate adder/subtractor is not built.

## Structure
- Shared defines file holds:
  - `op_i` encodings: `MULDIV_OP_*`.
  - FSM state encodings.
  - `MulDivBus` width macros.
- One sub-module, `div_restoring_step`: a combinational single iteration taking remainder, quotient and divisor, and returning next remainder and quotient. Instantiated once; FSM and multiply live in `muldiv_unit`.

## Test plan
All scenarios with WIDTH=32.
- MULT 0xFFFFFFFF × 0x00000007 → `ready_o` at start+33; `result_o` = 0xFFFFFFFF_FFFFFFF9; `busy_o` high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
- Signed DIV:
  - DIV 0xFFFFFFF9 (-7) / 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFD.
  - DIV 0x80000000 / 0xFFFFFFFF → HI=0, LO=0x80000000.
- DIVU 5 / 0 → `ready_o` at start+1, `div_zero_o`=1, `result_o` = 0x00000005_FFFFFFFF.
- Annul and ignored starts:
  - MULT started, `annul_i` at cycle 10 → no `ready_o`, `busy_o` low next cycle, `result_o` unchanged.
  - Immediate new start is accepted.
  - A start pulsed while busy is ignored.
- With `MULDIV_MADD_EN`, `hilo_i`=0x00000000_00000010:
  - MADD 3×4 → 0x00000000_0000001C.
  - MSUB 3×4 → 0x00000000_00000004.
  - MSUBU 1×0x20 → 0xFFFFFFFF_FFFFFFF0.
